// File: rtl/bitframe_rx.sv
// bitframe_rx: decodes '0'/'1' ASCII bit frames terminated by '*' into LEN-bit words.
// Define BITFRAME_RX_STATS_EN to add saturating good/bad frame counters.
module bitframe_rx #(
   parameter int LEN = 64
) (
   input  logic           clk_48mhz,
   input  logic           reset,
   input  logic [7:0]     in_data,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [LEN-1:0] frame_data,
   output logic           frame_valid,
   output logic           err_len,
   output logic           err_char,
   output logic [7:0]     bit_count
`ifdef BITFRAME_RX_STATS_EN
   ,
   output logic [15:0]    good_count,
   output logic [15:0]    bad_count
`endif
);
   typedef enum logic {SYNC, COLLECT} state_t;
   state_t state_q, state_d;
   logic [LEN-1:0] shadow_q, shadow_d;
   logic [7:0] count_d;
   logic hs, is_star, is_bit, fv_d, el_d, ec_d;
   assign in_ready = !reset;
   assign hs = in_valid && in_ready;
   assign is_star = in_data == 8'h2A;
   assign is_bit = in_data[7:1] == 7'h18;
   always_comb begin
      state_d = state_q;
      count_d = bit_count;
      shadow_d = shadow_q;
      fv_d = 1'b0;
      el_d = 1'b0;
      ec_d = 1'b0;
      if (hs && state_q == SYNC) begin
         state_d = is_star ? COLLECT : SYNC;
         count_d = 8'd0;
      end else if (hs && is_star) begin
         fv_d = bit_count == 8'(LEN);
         el_d = bit_count != 8'(LEN);
         count_d = 8'd0;
      end else if (hs && is_bit) begin
         count_d = bit_count + {7'd0, bit_count != 8'hFF};
         // Only positions below LEN exist; overlong frames are counted, not stored
         for (int i = 0; i < LEN; i++)
            if (bit_count == 8'(i)) shadow_d[i] = in_data[0];
      end else if (hs) begin
         ec_d = 1'b1;
         state_d = SYNC;
         count_d = 8'd0;
      end
   end
   always_ff @(posedge clk_48mhz) shadow_q <= shadow_d;
   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         state_q <= SYNC;
         bit_count <= 8'd0;
         frame_data <= '0;
         frame_valid <= 1'b0;
         err_len <= 1'b0;
         err_char <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_count <= count_d;
         frame_data <= fv_d ? shadow_q : frame_data;
         frame_valid <= fv_d;
         err_len <= el_d;
         err_char <= ec_d;
      end
   end
`ifdef BITFRAME_RX_STATS_EN
   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         good_count <= 16'd0;
         bad_count <= 16'd0;
      end else begin
         good_count <= good_count + {15'd0, fv_d && good_count != 16'hFFFF};
         bad_count <= bad_count + {15'd0, (el_d || ec_d) && bad_count != 16'hFFFF};
      end
   end
`endif
endmodule
